// File: rtl/ysyx_exu_if.sv
// Decoded instruction bundle travelling from the decode stage
// into the execute stage.
interface idu_pipe_if;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        speculation;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] opj;
    logic [3:0]  alu_op;
    logic [3:0]  rd;
    logic [31:0] imm;
    logic        ren;
    logic        wen;
    logic        jen;
    logic        ben;
    logic        system;
    logic        func3_z;
    logic        csr_wen;
    logic        ebreak;
    logic        ecall;
    logic        mret;

    modport in (
        input pc, inst, speculation, op1, op2, opj, alu_op, rd, imm,
        input ren, wen, jen, ben, system, func3_z, csr_wen,
        input ebreak, ecall, mret
    );

    modport out (
        output pc, inst, speculation, op1, op2, opj, alu_op, rd, imm,
        output ren, wen, jen, ben, system, func3_z, csr_wen,
        output ebreak, ecall, mret
    );
endinterface

// File: rtl/ysyx_exu.sv
// Execute stage: single-cycle ALU/branch/CSR work, registered
// result toward LSU/WBU, control-flow redirect and wrong-path drain.
module ysyx_exu #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] MCAUSE_ECALL = 32'd11
) (
    input  logic            clk,
    input  logic            rst_n,
    idu_pipe_if.in          idu,
    input  logic            idu_valid,
    output logic            idu_ready,
    output logic            exu_valid,
    input  logic            exu_ready,
    output logic [XLEN-1:0] exu_pc,
    output logic [3:0]      exu_rd,
    output logic [XLEN-1:0] exu_result,
    output logic [XLEN-1:0] exu_sdata,
    output logic            exu_ren,
    output logic            exu_wen,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            halt
);
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]      st;
    logic [XLEN-1:0] mstatus, mtvec, mepc, mcause;
    logic            exu_ebreak;

    logic            fire, drop, exec;
    logic [4:0]      sh;
    logic [XLEN-1:0] alu, jt, target, result, csr_old, csr_new;
    logic [11:0]     csr_addr;
    logic            csr_op, csr_we, cond, redir;
    logic            unused;

    assign unused    = ^{idu.inst[19:14], idu.inst[11:0]};
    assign idu_ready = (st != S_HALT) && (!exu_valid || exu_ready);
    assign fire      = idu_valid && idu_ready;
    assign drop      = (st == S_DRAIN) && idu.speculation;
    assign exec      = fire && !drop;
    assign sh        = idu.op2[4:0];

    always_comb begin
        alu = '0;
        case (idu.alu_op)
            4'd0:    alu = idu.op1 + idu.op2;
            4'd1:    alu = idu.op1 - idu.op2;
            4'd2:    alu = idu.op1 << sh;
            4'd3:    alu = {{(XLEN-1){1'b0}},
                            $signed(idu.op1) < $signed(idu.op2)};
            4'd4:    alu = {{(XLEN-1){1'b0}}, idu.op1 < idu.op2};
            4'd5:    alu = idu.op1 ^ idu.op2;
            4'd6:    alu = idu.op1 >> sh;
            4'd7:    alu = $signed(idu.op1) >>> sh;
            4'd8:    alu = idu.op1 | idu.op2;
            4'd9:    alu = idu.op1 & idu.op2;
            default: alu = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (idu.alu_op)
            4'hA:    cond = idu.op1 == idu.op2;
            4'hB:    cond = idu.op1 != idu.op2;
            4'hC:    cond = $signed(idu.op1) < $signed(idu.op2);
            4'hD:    cond = $signed(idu.op1) >= $signed(idu.op2);
            4'hE:    cond = idu.op1 < idu.op2;
            4'hF:    cond = idu.op1 >= idu.op2;
            default: cond = 1'b0;
        endcase
    end

    assign csr_addr = idu.inst[31:20];
    assign csr_op   = idu.system && !idu.func3_z && idu.csr_wen;

    always_comb begin
        case (csr_addr)
            12'h300: csr_old = mstatus;
            12'h305: csr_old = mtvec;
            12'h341: csr_old = mepc;
            12'h342: csr_old = mcause;
            default: csr_old = '0;
        endcase
    end

    // set/clear with a zero mask must not count as a write
    always_comb begin
        csr_we  = 1'b0;
        csr_new = csr_old;
        case (idu.inst[13:12])
            2'b01: begin
                csr_we  = 1'b1;
                csr_new = idu.op1;
            end
            2'b10: begin
                csr_we  = |idu.op1;
                csr_new = csr_old | idu.op1;
            end
            2'b11: begin
                csr_we  = |idu.op1;
                csr_new = csr_old & ~idu.op1;
            end
            default: ;
        endcase
    end

    assign jt    = idu.opj + idu.imm;
    assign redir = idu.jen || (idu.ben && cond) || idu.ecall || idu.mret;

    always_comb begin
        if (idu.jen)       target = {jt[XLEN-1:1], 1'b0};
        else if (idu.ben)  target = idu.pc + idu.imm;
        else if (idu.ecall) target = mtvec;
        else               target = mepc;
    end

    always_comb begin
        if (idu.jen)                  result = idu.pc + 32'd4;
        else if (idu.ren || idu.wen)  result = idu.op1 + idu.imm;
        else if (csr_op)              result = csr_old;
        else                          result = alu;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exu_valid  <= 1'b0;
            exu_pc     <= '0;
            exu_rd     <= '0;
            exu_result <= '0;
            exu_sdata  <= '0;
            exu_ren    <= 1'b0;
            exu_wen    <= 1'b0;
            exu_ebreak <= 1'b0;
        end else if (fire) begin
            exu_valid <= exec;
            if (exec) begin
                exu_pc     <= idu.pc;
                exu_rd     <= (idu.ben || idu.ecall || idu.mret ||
                               idu.ebreak) ? 4'd0 : idu.rd;
                exu_result <= result;
                exu_sdata  <= idu.op2;
                exu_ren    <= idu.ren;
                exu_wen    <= idu.wen;
                exu_ebreak <= idu.ebreak;
            end
        end else if (exu_ready) begin
            exu_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st             <= S_RUN;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            halt           <= 1'b0;
        end else begin
            redirect_valid <= exec && redir;
            if (exec && redir) redirect_pc <= target;
            if (exu_valid && exu_ready && exu_ebreak) halt <= 1'b1;
            if (exec) begin
                if (idu.ebreak) st <= S_HALT;
                else if (redir) st <= S_DRAIN;
                else            st <= S_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus <= 32'h0000_1800;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else if (exec && idu.ecall) begin
            mepc   <= idu.pc;
            mcause <= MCAUSE_ECALL;
        end else if (exec && csr_op && csr_we) begin
            case (csr_addr)
                12'h300: mstatus <= csr_new;
                12'h305: mtvec   <= csr_new;
                12'h341: mepc    <= csr_new;
                12'h342: mcause  <= csr_new;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_exu.sv
// Random + directed bench for ysyx_exu: reference model feeds an
// expected-result queue, a separate monitor pops and compares.
module tb_ysyx_exu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        idu_valid = 1'b0;
    logic        idu_ready;
    logic        exu_valid;
    logic        exu_ready = 1'b0;
    logic [31:0] exu_pc, exu_result, exu_sdata, redirect_pc;
    logic [3:0]  exu_rd;
    logic        exu_ren, exu_wen, redirect_valid, halt;

    always #5 clk = ~clk;

    idu_pipe_if idu ();

    ysyx_exu dut (
        .clk(clk), .rst_n(rst_n), .idu(idu.in),
        .idu_valid(idu_valid), .idu_ready(idu_ready),
        .exu_valid(exu_valid), .exu_ready(exu_ready),
        .exu_pc(exu_pc), .exu_rd(exu_rd), .exu_result(exu_result),
        .exu_sdata(exu_sdata), .exu_ren(exu_ren), .exu_wen(exu_wen),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt)
    );

    typedef struct {
        logic [31:0] pc, inst, op1, op2, opj, imm;
        logic [3:0]  alu_op, rd;
        logic spec, ren, wen, jen, ben, system, func3_z;
        logic csr_wen, ebreak, ecall, mret;
    } ins_t;

    typedef struct {
        logic [31:0] pc, result, sdata;
        logic [3:0]  rd;
        logic ren, wen, chk_res, ebrk;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          drain_m, halted_m;
    logic [31:0] csr[int];
    bit          exp_rv;
    logic [31:0] exp_rpc;
    bit          rdy_force = 1'b1;
    bit          rdy_val = 1'b1;
    bit          halt_exp, hx_pend;
    exp_t        me;

    function automatic void chk32(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endfunction

    function automatic void chk1(string nm, logic a, logic e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endfunction

    function automatic logic [31:0] csr_rd(int a);
        return csr.exists(a) ? csr[a] : 32'd0;
    endfunction

    function automatic void csr_wr(int a, logic [31:0] v);
        if (csr.exists(a)) csr[a] = v;
    endfunction

    function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int s = int'(b[4:0]);
        logic [31:0] fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0;
        case (op)
            4'd0: return a + b;
            4'd1: return a + ~b + 32'd1;
            4'd2: return a << s;
            4'd3: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'd4: return {31'd0, a < b};
            4'd5: return a ^ b;
            4'd6: return a >> s;
            4'd7: return (a >> s) | fill;
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit br_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        logic [31:0] sa = a ^ 32'h8000_0000;
        logic [31:0] sb = b ^ 32'h8000_0000;
        case (op)
            4'hA: return a == b;
            4'hB: return a != b;
            4'hC: return sa < sb;
            4'hD: return !(sa < sb);
            4'hE: return a < b;
            4'hF: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model(input ins_t x, output bit keep, output exp_t e,
                                  output bit rv, output logic [31:0] rpc, output bit hlt);
        logic [31:0] old;
        int ad;
        bit nord;
        keep = 0; rv = 0; rpc = 0; hlt = 0;
        e = '{default: 0};
        if (drain_m && x.spec) return;
        keep = 1;
        nord = x.ben || x.ecall || x.mret || x.ebreak;
        e.pc = x.pc; e.sdata = x.op2; e.ren = x.ren; e.wen = x.wen;
        e.ebrk = x.ebreak; e.chk_res = !nord;
        e.rd = nord ? 4'd0 : x.rd;
        ad = int'(x.inst[31:20]);
        old = csr_rd(ad);
        if (x.jen) begin
            e.result = x.pc + 32'd4;
            rv = 1; rpc = (x.opj + x.imm) & 32'hFFFF_FFFE;
        end else if (x.ren || x.wen) begin
            e.result = x.op1 + x.imm;
        end else if (x.system && !x.func3_z && x.csr_wen) begin
            e.result = old;
            case (x.inst[13:12])
                2'b01: csr_wr(ad, x.op1);
                2'b10: if (x.op1 != 0) csr_wr(ad, old | x.op1);
                2'b11: if (x.op1 != 0) csr_wr(ad, old & ~x.op1);
                default: ;
            endcase
        end else begin
            e.result = alu_ref(x.alu_op, x.op1, x.op2);
        end
        if (x.ben && br_ref(x.alu_op, x.op1, x.op2)) begin
            rv = 1; rpc = x.pc + x.imm;
        end
        if (x.ecall) begin
            rv = 1; rpc = csr_rd('h305);
            csr_wr('h341, x.pc); csr_wr('h342, 32'd11);
        end
        if (x.mret) begin
            rv = 1; rpc = csr_rd('h341);
        end
        hlt = x.ebreak;
        drain_m = rv;
    endfunction

    task automatic drive(input ins_t x);
        idu.pc = x.pc; idu.inst = x.inst; idu.speculation = x.spec;
        idu.op1 = x.op1; idu.op2 = x.op2; idu.opj = x.opj;
        idu.alu_op = x.alu_op; idu.rd = x.rd; idu.imm = x.imm;
        idu.ren = x.ren; idu.wen = x.wen; idu.jen = x.jen; idu.ben = x.ben;
        idu.system = x.system; idu.func3_z = x.func3_z;
        idu.csr_wen = x.csr_wen; idu.ebreak = x.ebreak;
        idu.ecall = x.ecall; idu.mret = x.mret;
    endtask

    task automatic step(input bit have, input ins_t x, output bit acc);
        exp_t e;
        bit keep, rv, hlt;
        logic [31:0] rpc;
        @(negedge clk);
        #2;
        drive(x);
        idu_valid = have;
        exu_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        #1;
        acc = have && idu_ready;
        keep = 0; rv = 0; hlt = 0; rpc = 0;
        if (acc) model(x, keep, e, rv, rpc, hlt);
        @(posedge clk);
        if (keep) q.push_back(e);
        if (hlt) halted_m = 1;
        exp_rv = rv;
        exp_rpc = rpc;
    endtask

    task automatic issue(input ins_t x);
        bit acc;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, x, acc);
            if (acc) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL issue_timeout: got no accept expected accept pc=%h", x.pc);
    endtask

    task automatic idle(input int n);
        ins_t z;
        bit acc;
        z = '{default: 0};
        repeat (n) step(1'b0, z, acc);
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        idu_valid = 1'b0;
        #1;
        chk1("rst_exu_valid", exu_valid, 1'b0);
        chk1("rst_redirect", redirect_valid, 1'b0);
        chk1("rst_halt", halt, 1'b0);
        chk32("rst_pc", exu_pc, 32'd0);
        chk32("rst_result", exu_result, 32'd0);
        chk32("rst_sdata", exu_sdata, 32'd0);
        chk32("rst_rd", {28'd0, exu_rd}, 32'd0);
        chk1("rst_ren", exu_ren, 1'b0);
        chk1("rst_wen", exu_wen, 1'b0);
        q.delete();
        drain_m = 0; halted_m = 0; exp_rv = 0;
        csr.delete();
        csr['h300] = 32'h1800; csr['h305] = 0; csr['h341] = 0; csr['h342] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic ins_t mk_alu(logic [31:0] pc, logic [3:0] op,
                                    logic [31:0] a, logic [31:0] b, logic [3:0] rd);
        ins_t x = '{default: 0};
        x.pc = pc; x.alu_op = op; x.op1 = a; x.op2 = b; x.rd = rd;
        return x;
    endfunction

    function automatic ins_t mk_csr(logic [11:0] ad, logic [1:0] f,
                                    logic [31:0] a, logic [3:0] rd);
        ins_t x = '{default: 0};
        x.system = 1; x.csr_wen = 1; x.op1 = a; x.rd = rd; x.pc = 32'h40;
        x.inst = {ad, 5'd0, 1'b0, f, 5'(rd), 7'h73};
        return x;
    endfunction

    function automatic ins_t gen();
        ins_t x = '{default: 0};
        logic [31:0] in_;
        logic [11:0] ad;
        x.pc = $urandom & 32'hFFFF_FFFC;
        x.op1 = $urandom; x.op2 = $urandom;
        x.rd = 4'($urandom_range(0, 15));
        x.spec = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 9))
            0, 1, 2, 3: x.alu_op = 4'($urandom_range(0, 9));
            4: begin
                x.imm = $urandom;
                if ($urandom_range(0, 1) == 0) x.ren = 1; else x.wen = 1;
            end
            5: begin x.jen = 1; x.opj = $urandom; x.imm = $urandom; end
            6: begin
                x.ben = 1; x.imm = $urandom;
                x.alu_op = 4'($urandom_range(10, 15));
                if ($urandom_range(0, 2) == 0) x.op2 = x.op1;
            end
            7: begin
                case ($urandom_range(0, 4))
                    0: ad = 12'h300;
                    1: ad = 12'h305;
                    2: ad = 12'h341;
                    3: ad = 12'h342;
                    default: ad = 12'h123;
                endcase
                in_ = $urandom;
                in_[31:20] = ad;
                in_[13:12] = 2'($urandom_range(1, 3));
                x.inst = in_; x.system = 1; x.csr_wen = 1;
                if ($urandom_range(0, 3) == 0) x.op1 = 0;
            end
            8: begin x.system = 1; x.func3_z = 1; x.ecall = 1; end
            default: begin x.system = 1; x.func3_z = 1; x.mret = 1; end
        endcase
        return x;
    endfunction

    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            halt_exp = 0;
            hx_pend = 0;
        end else begin
            if (hx_pend) begin halt_exp = 1; hx_pend = 0; end
            chk1("halt", halt, halt_exp);
            chk1("exu_valid", exu_valid, q.size() != 0);
            chk1("idu_ready", idu_ready, !halted_m && (q.size() == 0 || exu_ready));
            chk1("redirect_valid", redirect_valid, exp_rv);
            if (exp_rv) chk32("redirect_pc", redirect_pc, exp_rpc);
            if (exu_valid && q.size() != 0) begin
                me = q[0];
                chk32("exu_pc", exu_pc, me.pc);
                chk32("exu_rd", {28'd0, exu_rd}, {28'd0, me.rd});
                chk32("exu_sdata", exu_sdata, me.sdata);
                chk1("exu_ren", exu_ren, me.ren);
                chk1("exu_wen", exu_wen, me.wen);
                if (me.chk_res) chk32("exu_result", exu_result, me.result);
                if (exu_ready) begin
                    void'(q.pop_front());
                    if (me.ebrk) hx_pend = 1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t x;
        bit acc;
        do_reset();
        idle(1);

        issue(mk_alu(32'h1000, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd1));
        issue(mk_alu(32'h1004, 4'd7, 32'h8000_0000, 32'd4, 4'd2));
        issue(mk_alu(32'h1008, 4'd4, 32'd1, 32'hFFFF_FFFF, 4'd3));
        idle(2);

        x = mk_alu(32'h8000_0010, 4'hB, 32'd1, 32'd2, 4'd6);
        x.ben = 1; x.imm = 32'hFFFF_FFF0;
        issue(x);
        x = mk_alu(32'h8000_0014, 4'd0, 32'd5, 32'd6, 4'd7); x.spec = 1;
        issue(x);
        x.pc = 32'h8000_0018;
        issue(x);
        issue(mk_alu(32'h8000_0000, 4'd8, 32'hF0, 32'h0F, 4'd8));
        idle(2);

        x = '{default: 0};
        x.jen = 1; x.pc = 32'h100; x.opj = 32'h200; x.imm = 32'd5; x.rd = 4'd1;
        issue(x);
        idle(2);

        issue(mk_csr(12'h305, 2'b01, 32'h8000_0400, 4'd3));
        x = '{default: 0};
        x.system = 1; x.func3_z = 1; x.ecall = 1; x.pc = 32'h80; x.rd = 4'd9;
        issue(x);
        issue(mk_csr(12'h341, 2'b10, 32'd0, 4'd4));
        issue(mk_csr(12'h342, 2'b10, 32'd0, 4'd5));
        x = '{default: 0};
        x.system = 1; x.func3_z = 1; x.mret = 1; x.pc = 32'h90;
        issue(x);
        idle(2);

        rdy_val = 0;
        issue(mk_alu(32'h2000, 4'd5, 32'hAAAA_0000, 32'h0000_5555, 4'd10));
        x = mk_alu(32'h2004, 4'd1, 32'd3, 32'd5, 4'd11);
        repeat (3) begin
            step(1'b1, x, acc);
            chk1("bp_stall", acc, 1'b0);
        end
        rdy_val = 1;
        step(1'b1, x, acc);
        chk1("bp_release", acc, 1'b1);
        idle(2);

        rdy_force = 0;
        repeat (400) begin
            issue(gen());
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        rdy_force = 1; rdy_val = 1;
        idle(3);

        x = '{default: 0};
        x.system = 1; x.func3_z = 1; x.ebreak = 1; x.pc = 32'h300; x.rd = 4'd7;
        issue(x);
        idle(3);
        chk1("halt_set", halt, 1'b1);
        x = mk_alu(32'h304, 4'd0, 32'd1, 32'd1, 4'd2);
        repeat (3) begin
            step(1'b1, x, acc);
            chk1("halt_block", acc, 1'b0);
        end
        do_reset();
        idle(2);

        rdy_val = 0;
        issue(mk_alu(32'h400, 4'd2, 32'd1, 32'd31, 4'd12));
        idle(1);
        do_reset();
        rdy_val = 1;
        idle(2);
        issue(mk_alu(32'h500, 4'd9, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd13));
        idle(3);
        chk32("q_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
